param_seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider: control FSM, iteration counter and shift/subtract datapath in one block. Generalises the fixed 32-bit unsigned divider to WIDTH bits, with an optional signed mode and divide-by-zero detection. Uses a run/rdy/busy handshake. Sits beside the ALU as the DIV/REM execution unit for the single-cycle/multi-cycle CPU datapath.

---
 rtl/param_seq_divider.sv | 151 +++++++++++++++
 tb/tb_param_seq_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_divider.sv
// Multi-cycle restoring divider (DIV/REM unit): one quotient bit per clock,
// optional two's-complement mode, divide-by-zero reported with the results.
module param_seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             rdy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] quo_q,       quo_d;
    logic [WIDTH-1:0] dvs_q,       dvs_d;
    logic [WIDTH-1:0] raw_dvd_q,   raw_dvd_d;
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
    logic             dz_q,        dz_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             rdy_q,       rdy_d;
    logic             dz_out_q,    dz_out_d;

    logic             sm;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [WIDTH-1:0] shifted_lo;
    logic             ge;

    assign sm      = signed_mode & SIGNED_EN;
    assign abs_dvd = (sm && dividend[WIDTH-1]) ? -dividend : dividend;
    assign abs_dvs = (sm && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The WIDTH+1-bit shifted remainder is {rem_q[MSB], shifted_lo}; when that
    // carry bit is set the value already exceeds any divisor, and the low
    // WIDTH bits of the difference are exact because the result fits.
    assign shifted_lo = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign ge         = rem_q[WIDTH-1] | (shifted_lo >= dvs_q);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        raw_dvd_d   = raw_dvd_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        rdy_d       = 1'b0;
        dz_out_d    = dz_out_q;

        case (state_q)
            IDLE: begin
                if (run) begin
                    raw_dvd_d = dividend;
                    neg_quo_d = sm & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = sm & dividend[WIDTH-1];
                    quo_d     = abs_dvd;
                    dvs_d     = abs_dvs;
                    rem_d     = '0;
                    count_d   = '0;
                    dz_d      = (divisor == '0);
                    state_d   = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d   = ge ? (shifted_lo - dvs_q) : shifted_lo;
                quo_d   = {quo_q[WIDTH-2:0], ge};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = raw_dvd_q;
                end else begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                end
                dz_out_d = dz_q;
                rdy_d    = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            raw_dvd_q   <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            rdy_q       <= 1'b0;
            dz_out_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            raw_dvd_q   <= raw_dvd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            rdy_q       <= rdy_d;
            dz_out_q    <= dz_out_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q != IDLE);
    assign rdy         = rdy_q;
    assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_param_seq_divider.sv
// Directed and randomized checks of param_seq_divider (32-bit signed-capable
// and 8-bit unsigned-only instances) against an arithmetic reference model.
module tb_param_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        run32 = 1'b0, sm32 = 1'b0;
    logic [31:0] dvd32 = '0, dvs32 = '0;
    logic [31:0] q32, r32;
    logic        busy32, rdy32, dz32;

    logic        run8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  dvd8 = '0, dvs8 = '0;
    logic [7:0]  q8, r8;
    logic        busy8, rdy8, dz8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    param_seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .run(run32), .signed_mode(sm32),
        .dividend(dvd32), .divisor(dvs32), .quotient(q32), .remainder(r32),
        .busy(busy32), .rdy(rdy32), .div_by_zero(dz32)
    );

    param_seq_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .run(run8), .signed_mode(sm8),
        .dividend(dvd8), .divisor(dvs8), .quotient(q8), .remainder(r8),
        .busy(busy8), .rdy(rdy8), .div_by_zero(dz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Truncating division on 64-bit integers; sign rules come from SV's / and %.
    function automatic void model32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            q = '1; r = a; z = 1'b1;
        end else if (sm) begin
            q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Caller is #1 after a clock edge with dut32 idle.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input int poke_at, input string tag);
        logic [31:0] eq, er;
        logic        ez;
        int          n, nb, exp_n;
        model32(a, b, sm, eq, er, ez);
        exp_n = ez ? 1 : 33;
        run32 = 1'b1; dvd32 = a; dvs32 = b; sm32 = sm;
        @(posedge clk); #1;
        run32 = 1'b0;
        n = 0; nb = 0;
        while (!rdy32 && n < 200) begin
            if (busy32) nb++;
            if (n == poke_at) begin
                run32 = 1'b1; dvd32 = ~a; dvs32 = b + 32'd3; sm32 = ~sm;
            end else if (n == poke_at + 1) begin
                run32 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/latency"}, 64'(n), 64'(exp_n));
        check({tag, "/busy_cycles"}, 64'(nb), 64'(exp_n));
        check({tag, "/quotient"}, 64'(q32), 64'(eq));
        check({tag, "/remainder"}, 64'(r32), 64'(er));
        check({tag, "/div_by_zero"}, 64'(dz32), 64'(ez));
        @(posedge clk); #1;
        check({tag, "/rdy_pulse"}, 64'(rdy32), 64'd0);
        check({tag, "/held"}, {q32, r32}, {eq, er});
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm, input string tag);
        logic [7:0] eq, er;
        logic       ez;
        int         n, exp_n;
        ez = (b == 8'd0);
        eq = ez ? 8'hFF : a / b;
        er = ez ? a : a % b;
        exp_n = ez ? 1 : 9;
        run8 = 1'b1; dvd8 = a; dvs8 = b; sm8 = sm;
        @(posedge clk); #1;
        run8 = 1'b0;
        n = 0;
        while (!rdy8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/latency"}, 64'(n), 64'(exp_n));
        check({tag, "/quotient"}, 64'(q8), 64'(eq));
        check({tag, "/remainder"}, 64'(r8), 64'(er));
        check({tag, "/div_by_zero"}, 64'(dz8), 64'(ez));
        @(posedge clk); #1;
        check({tag, "/rdy_pulse"}, 64'(rdy8), 64'd0);
    endtask

    initial begin
        int n, rdy_seen;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("reset/q32", {q32, r32}, 64'd0);
        check("reset/flags32", {busy32, rdy32, dz32}, 64'd0);
        check("reset/dut8", {q8, r8, busy8, rdy8, dz8}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op32(32'd100, 32'd7, 1'b0, -1, "u100_7");
        op32(32'hFFFF_FFF9, 32'd2, 1'b1, -1, "s-7_2");
        op32(32'd7, 32'hFFFF_FFFE, 1'b1, -1, "s7_-2");
        op32(32'hFFFF_FFF9, 32'd2, 1'b0, -1, "u_fff9_2");
        op32(32'h1234, 32'd0, 1'b0, -1, "dz");
        op32(32'd50, 32'd5, 1'b1, -1, "after_dz");
        op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "min_-1");
        op32(32'hFFFF_FFFF, 32'd1, 1'b0, -1, "uffff_1");
        op32(32'hFFFF_FFF9, 32'd0, 1'b1, -1, "dz_signed");
        op32(32'd100, 32'd7, 1'b0, 5, "run_mid_calc");

        // Reset ten edges into an operation: outputs clear, no completion follows.
        run32 = 1'b1; dvd32 = 32'd999; dvs32 = 32'd4; sm32 = 1'b0;
        @(posedge clk); #1;
        run32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset/results", {q32, r32}, 64'd0);
        check("midreset/flags", {busy32, rdy32, dz32}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rdy32 || busy32) rdy_seen++;
        end
        check("midreset/no_rdy", 64'(rdy_seen), 64'd0);
        op32(32'd999, 32'd4, 1'b0, -1, "restart");

        // Back-to-back: run held high, second op accepted on the rdy cycle.
        run32 = 1'b1; dvd32 = 32'd1000; dvs32 = 32'd10; sm32 = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (!rdy32 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b/first_latency", 64'(n), 64'd33);
        check("b2b/first_result", {q32, r32}, {32'd100, 32'd0});
        dvd32 = 32'd77; dvs32 = 32'd5;
        @(posedge clk); #1;
        run32 = 1'b0;
        check("b2b/second_accepted", 64'(busy32), 64'd1);
        n = 0;
        while (!rdy32 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b/second_latency", 64'(n), 64'd33);
        check("b2b/second_result", {q32, r32}, {32'd15, 32'd2});
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            ra = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            op32(ra, rb, 1'($urandom_range(0, 1)), -1, $sformatf("rand32_%0d", i));
        end

        op8(8'd200, 8'd3, 1'b1, "w8_200_3");
        op8(8'hF9, 8'd2, 1'b1, "w8_sm_ignored");
        op8(8'h55, 8'd0, 1'b0, "w8_dz");
        for (int i = 0; i < 10; i++) begin
            op8(8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                $sformatf("rand8_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
